// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display path.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int CODE_W     = 4;
  localparam int POS_W      = 3;

  localparam logic [CODE_W-1:0] DIGIT_BLANK = 4'd10;
  localparam logic [CODE_W-1:0] DIGIT_DASH  = 4'd11;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [POS_W-1:0]  pos_t;

  typedef struct packed {
    logic [NUM_DIGITS*CODE_W-1:0] digits;
    logic [NUM_DIGITS-1:0]        dp;
  } frame_t;

  localparam frame_t FRAME_BLANK = '{digits: {NUM_DIGITS{DIGIT_BLANK}}, dp: 8'h00};

  function automatic code_t digit_at(input frame_t f, input pos_t pos);
    return f.digits[{pos, 2'b00} +: CODE_W];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Frame-load handshake and per-slot display outputs of the scan controller.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic        load;
  logic [31:0] load_digits;
  logic [7:0]  load_dp;
  logic        load_ready;
  code_t       digit;
  logic        current_dp;
  pos_t        position;
  logic        frame_start;

  modport master (
    output load, load_digits, load_dp,
    input  load_ready, digit, current_dp, position, frame_start
  );

  modport slave (
    input  load, load_digits, load_dp,
    output load_ready, digit, current_dp, position, frame_start
  );

endinterface

// File: rtl/seg_slot_timer.sv
// Free-running slot counter; flags the last cycle of a slot and whether the
// next cycle falls inside the blanking window.
module seg_slot_timer #(
  parameter int SLOT_CYCLES  = 10,
  parameter int BLANK_CYCLES = 2,
  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt_o,
  output logic             slot_end_o,
  output logic             blank_next_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count and slot/blank flags.
  always_comb begin
    cnt_d        = cnt_q;
    slot_end_o   = (cnt_q == CNT_W'(SLOT_CYCLES - 1));
    if (slot_end_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    blank_next_o = (cnt_d < CNT_W'(BLANK_CYCLES));
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit scan controller: double-buffered frame, tear-free commit at the
// 7->0 wrap, blanking at the start of each slot.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int SLOT_HZ      = 1000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic            clk,
  input  logic            rst_n,
  seg_scan_ctrl_if.slave  bus
);

  localparam int SLOT_CYCLES = CLK_HZ / SLOT_HZ;
  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_s;
  logic             slot_end_s;
  logic             blank_next_s;
  logic             wrap_s;

  pos_t   position_q, position_d;
  frame_t active_q, active_d;
  frame_t pend_q, pend_d;
  logic   pend_valid_q, pend_valid_d;
  logic   load_ready_q, load_ready_d;
  code_t  digit_q, digit_d;
  logic   dp_q, dp_d;
  logic   frame_start_q, frame_start_d;

  seg_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .cnt_o        (cnt_s),
    .slot_end_o   (slot_end_s),
    .blank_next_o (blank_next_s)
  );

  assign wrap_s = slot_end_s && (position_q == 3'd7);

  // Scan position, buffer/handshake next state and display outputs.
  always_comb begin
    position_d    = position_q;
    active_d      = active_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    load_ready_d  = load_ready_q;
    digit_d       = DIGIT_BLANK;
    dp_d          = 1'b0;
    frame_start_d = wrap_s;

    if (slot_end_s) begin
      position_d = position_q + 3'd1;
    end else begin
      position_d = position_q;
    end

    // Pending is empty whenever load_ready is high, so commit and capture
    // never compete; a load on the wrap edge waits for the next wrap.
    if (wrap_s && pend_valid_q) begin
      active_d     = pend_q;
      pend_valid_d = 1'b0;
      load_ready_d = 1'b1;
    end else if (bus.load && load_ready_q) begin
      pend_d       = '{digits: bus.load_digits, dp: bus.load_dp};
      pend_valid_d = 1'b1;
      load_ready_d = 1'b0;
    end else begin
      pend_valid_d = pend_valid_q;
    end

    if (blank_next_s) begin
      digit_d = DIGIT_BLANK;
      dp_d    = 1'b0;
    end else begin
      digit_d = digit_at(active_d, position_d);
      dp_d    = active_d.dp[position_d];
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      position_q    <= 3'd0;
      active_q      <= FRAME_BLANK;
      pend_q        <= FRAME_BLANK;
      pend_valid_q  <= 1'b0;
      load_ready_q  <= 1'b1;
      digit_q       <= DIGIT_BLANK;
      dp_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      position_q    <= position_d;
      active_q      <= active_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      load_ready_q  <= load_ready_d;
      digit_q       <= digit_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.digit       = digit_q;
  assign bus.current_dp  = dp_q;
  assign bus.position    = position_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized bench for seg_scan_ctrl against a cycle-count based reference model.
module tb_seg_scan_ctrl;

  localparam int SLOT  = 10;
  localparam int BLANK = 2;
  localparam int FRAME = SLOT * 8;

  logic clk;
  logic rst_n;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .CLK_HZ       (1000),
    .SLOT_HZ      (100),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: everything follows from n = clock edges since reset release.
  int          m_n;
  logic [31:0] m_act_digits;
  logic [7:0]  m_act_dp;
  logic [31:0] m_pend_digits;
  logic [7:0]  m_pend_dp;
  bit          m_pend_valid;
  bit          m_fs;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s n=%0d got=%0d exp=%0d", tag, m_n, got, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic ld, input logic [31:0] d, input logic [7:0] p);
    if (!rst) begin
      m_n          = 0;
      m_act_digits = 32'hAAAA_AAAA;
      m_act_dp     = 8'h00;
      m_pend_valid = 0;
      m_fs         = 0;
    end else begin
      m_fs = ((m_n + 1) % FRAME) == 0;
      if (m_fs && m_pend_valid) begin
        m_act_digits = m_pend_digits;
        m_act_dp     = m_pend_dp;
        m_pend_valid = 0;
      end else if (ld && !m_pend_valid) begin
        m_pend_digits = d;
        m_pend_dp     = p;
        m_pend_valid  = 1;
      end
      m_n++;
    end
  endtask

  task automatic compare_all();
    int pos;
    int exp_digit;
    int exp_dp;
    pos = (m_n / SLOT) % 8;
    if ((m_n % SLOT) < BLANK) begin
      exp_digit = 10;
      exp_dp    = 0;
    end else begin
      exp_digit = (m_act_digits >> (4 * pos)) & 32'hF;
      exp_dp    = (m_act_dp >> pos) & 8'h1;
    end
    check("position",    int'(bus.position),    pos);
    check("digit",       int'(bus.digit),       exp_digit);
    check("current_dp",  int'(bus.current_dp),  exp_dp);
    check("load_ready",  int'(bus.load_ready),  m_pend_valid ? 0 : 1);
    check("frame_start", int'(bus.frame_start), m_fs ? 1 : 0);
  endtask

  task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] p);
    bus.load        = ld;
    bus.load_digits = d;
    bus.load_dp     = p;
    @(posedge clk);
    model_edge(rst_n, ld, d, p);
    #1;
    compare_all();
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 32'h0, 8'h00);
  endtask

  // Idle until the next edge lands on the given frame phase (bounded by one frame).
  task automatic run_to(input int phase);
    for (int i = 0; i < FRAME && (m_n % FRAME) != phase; i++) step(1'b0, 32'h0, 8'h00);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) step(1'b0, 32'hFFFF_FFFF, 8'hFF);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] rp;
    bus.load        = 1'b0;
    bus.load_digits = 32'h0;
    bus.load_dp     = 8'h00;
    rst_n           = 1'b0;
    m_n = 0; m_act_digits = 32'hAAAA_AAAA; m_act_dp = 8'h00;
    m_pend_digits = 32'h0; m_pend_dp = 8'h00; m_pend_valid = 0; m_fs = 0;

    do_reset(2);
    idle(200);

    // Mid-frame load, then an ignored second load while pending is full.
    run_to(35);
    step(1'b1, 32'h7654_3210, 8'h04);
    step(1'b1, 32'h9999_9999, 8'hFF);
    idle(200);

    // Load on the wrap cycle with pending empty.
    run_to(FRAME - 1);
    step(1'b1, 32'hBA98_7654, 8'h81);
    idle(170);

    // Reset mid-frame with a frame pending.
    run_to(20);
    step(1'b1, 32'h1111_2222, 8'hF0);
    run_to(40);
    do_reset(2);
    idle(200);

    for (int i = 0; i < 1500; i++) begin
      rd = $urandom;
      rp = $urandom;
      step(($urandom_range(0, 19) == 0), rd, rp[7:0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
